// File: rtl/ex_stage_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_stage_unit                                                              |
// | LC-3b execute stage: address generation, ALU/shifts, iterative MUL, and a  |
// | one-entry valid/ready output slot.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ex_stage_unit #(
  parameter int WIDTH      = 16,
  parameter int MUL_ENABLE = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluop,
  input  logic [15:0]      in_ir,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_sr1,
  input  logic [WIDTH-1:0] in_sr2,
  input  logic             in_basesel,
  input  logic [1:0]       in_offsel,
  input  logic             in_addrsel,
  input  logic             in_immsel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alu,
  output logic [WIDTH-1:0] out_address,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int c_shamt_w = $clog2(WIDTH);
  localparam int c_cnt_w   = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
  localparam logic [3:0] c_op_mul = 4'd8;
  localparam int c_x_sext5 = 0;
  localparam int c_x_adj6  = 1;
  localparam int c_x_adj9  = 2;
  localparam int c_x_adj11 = 3;
  localparam int c_x_trap  = 4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [4:0][15:0]      w_ext16;
  logic [4:0][WIDTH-1:0] w_ext;
  logic [WIDTH-1:0]      w_base, w_off, w_addr, w_a, w_b, w_alu, w_partial;
  logic [c_shamt_w-1:0]  w_shamt;
  logic                  w_accept, w_is_mul, w_load_single, w_mul_done;

  logic [WIDTH-1:0]   r_ma, r_mb, r_acc, r_maddr;
  logic [TAG_W-1:0]   r_mtag;
  logic [c_cnt_w-1:0] r_cnt;

  // Immediates are formed in a 16-bit domain (ir is 16 bits) and then resized.
  assign w_ext16[c_x_sext5] = {{11{in_ir[4]}}, in_ir[4:0]};
  assign w_ext16[c_x_adj6]  = {{9{in_ir[5]}}, in_ir[5:0], 1'b0};
  assign w_ext16[c_x_adj9]  = {{6{in_ir[8]}}, in_ir[8:0], 1'b0};
  assign w_ext16[c_x_adj11] = {{4{in_ir[10]}}, in_ir[10:0], 1'b0};
  assign w_ext16[c_x_trap]  = {7'b0, in_ir[7:0], 1'b0};

  generate
    for (genvar i = 0; i < 5; i++) begin : g_ext
      if (WIDTH > 16) begin : g_wide
        assign w_ext[i] = {{(WIDTH-16){w_ext16[i][15]}}, w_ext16[i]};
      end else begin : g_fit
        assign w_ext[i] = w_ext16[i][WIDTH-1:0];
      end
    end
  endgenerate

  assign w_base = in_basesel ? in_sr1 : in_pc;

  always_comb begin
    w_off = '0;
    case (in_offsel)
      2'd1:    w_off = w_ext[c_x_adj6];
      2'd2:    w_off = w_ext[c_x_adj9];
      2'd3:    w_off = w_ext[c_x_adj11];
      default: w_off = '0;
    endcase
  end

  assign w_addr  = in_addrsel ? (w_base + w_off) : w_ext[c_x_trap];
  assign w_a     = in_sr1;
  assign w_b     = in_immsel ? w_ext[c_x_sext5] : in_sr2;
  assign w_shamt = w_b[c_shamt_w-1:0];

  always_comb begin
    w_alu = w_a;
    case (in_aluop)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a & w_b;
      4'd2:    w_alu = ~w_a;
      4'd3:    w_alu = w_a;
      4'd4:    w_alu = w_b;
      4'd5:    w_alu = w_a << w_shamt;
      4'd6:    w_alu = w_a >> w_shamt;
      4'd7:    w_alu = $signed(w_a) >>> w_shamt;
      4'd8:    w_alu = '0;
      default: w_alu = w_a;
    endcase
  end

  assign in_ready      = (r_state != S_MUL) && (!out_valid || out_ready);
  assign busy          = (r_state == S_MUL);
  assign w_accept      = in_valid && in_ready && !flush;
  assign w_is_mul      = (in_aluop == c_op_mul) && (MUL_ENABLE != 0);
  assign w_load_single = w_accept && !w_is_mul;
  assign w_mul_done    = (r_state == S_MUL) && (r_cnt == c_last) && !flush;
  // One shift-add step: the multiplicand moves left as the multiplier moves right.
  assign w_partial     = r_acc + (r_mb[0] ? r_ma : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
      S_MUL:   if (r_cnt == c_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_alu     <= '0;
      out_address <= '0;
      out_tag     <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_maddr     <= '0;
      r_mtag      <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_load_single) begin
        out_valid   <= 1'b1;
        out_alu     <= w_alu;
        out_address <= w_addr;
        out_tag     <= in_tag;
      end else if (w_mul_done) begin
        out_valid   <= 1'b1;
        out_alu     <= w_partial;
        out_address <= r_maddr;
        out_tag     <= r_mtag;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (w_accept && w_is_mul) begin
        r_ma    <= w_a;
        r_mb    <= w_b;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_maddr <= w_addr;
        r_mtag  <= in_tag;
      end else if (r_state == S_MUL) begin
        r_acc <= w_partial;
        r_ma  <= r_ma << 1;
        r_mb  <= r_mb >> 1;
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ex_stage_unit                                                           |
// | Directed and randomized checks of ex_stage_unit against an arithmetic model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ex_stage_unit;

  localparam int c_w = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            nm_valid = 1'b0;
  logic [3:0]      in_aluop = '0;
  logic [15:0]     in_ir = '0;
  logic [c_w-1:0]  in_pc = '0, in_sr1 = '0, in_sr2 = '0;
  logic            in_basesel = 1'b0, in_addrsel = 1'b0, in_immsel = 1'b0;
  logic [1:0]      in_offsel = '0;
  logic [3:0]      in_tag = '0;
  logic            out_ready = 1'b1;

  logic            in_ready, out_valid, busy;
  logic [c_w-1:0]  out_alu, out_address;
  logic [3:0]      out_tag;
  logic            nm_in_ready, nm_out_valid, nm_busy;
  logic [c_w-1:0]  nm_out_alu, nm_out_address;
  logic [3:0]      nm_out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage_unit #(.WIDTH(c_w), .MUL_ENABLE(1), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_ir(in_ir), .in_pc(in_pc), .in_sr1(in_sr1), .in_sr2(in_sr2),
    .in_basesel(in_basesel), .in_offsel(in_offsel), .in_addrsel(in_addrsel),
    .in_immsel(in_immsel), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_address(out_address), .out_tag(out_tag), .busy(busy)
  );

  ex_stage_unit #(.WIDTH(c_w), .MUL_ENABLE(0), .TAG_W(4)) u_dut_nm (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(nm_valid), .in_ready(nm_in_ready),
    .in_aluop(in_aluop), .in_ir(in_ir), .in_pc(in_pc), .in_sr1(in_sr1), .in_sr2(in_sr2),
    .in_basesel(in_basesel), .in_offsel(in_offsel), .in_addrsel(in_addrsel),
    .in_immsel(in_immsel), .in_tag(in_tag), .out_valid(nm_out_valid), .out_ready(1'b1),
    .out_alu(nm_out_alu), .out_address(nm_out_address), .out_tag(nm_out_tag), .busy(nm_busy)
  );

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic int wrap(longint v);
    return int'(((v % 65536) + 65536) % 65536);
  endfunction

  function automatic int sx(int v, int n);
    int f;
    f = v % (1 << n);
    return (f >= (1 << (n - 1))) ? f - (1 << n) : f;
  endfunction

  function automatic int m_b(int ir, int immsel, int sr2);
    return immsel != 0 ? wrap(longint'(sx(ir, 5))) : sr2;
  endfunction

  function automatic int m_addr(int ir, int pc, int sr1, int basesel, int offsel, int addrsel);
    int base, off;
    if (addrsel == 0) return (ir % 256) * 2;
    base = (basesel != 0) ? sr1 : pc;
    case (offsel)
      1:       off = sx(ir, 6) * 2;
      2:       off = sx(ir, 9) * 2;
      3:       off = sx(ir, 11) * 2;
      default: off = 0;
    endcase
    return wrap(longint'(base + off));
  endfunction

  function automatic int m_alu(int op, int a, int b);
    int amt, sa;
    amt = b % 16;
    sa  = (a >= 32768) ? a - 65536 : a;
    case (op)
      0:       return wrap(longint'(a + b));
      1:       return a & b;
      2:       return 65535 - a;
      4:       return b;
      5:       return wrap(longint'(a) * (longint'(1) << amt));
      6:       return a / (1 << amt);
      7:       return wrap(longint'(sa >>> amt));
      8:       return wrap(longint'(a) * longint'(b));
      default: return a;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int ir, input int pc, input int sr1, input int sr2,
                       input int bsel, input int osel, input int asel, input int isel, input int tag);
    in_aluop   = 4'(op);
    in_ir      = 16'(ir);
    in_pc      = 16'(pc);
    in_sr1     = 16'(sr1);
    in_sr2     = 16'(sr2);
    in_basesel = 1'(bsel);
    in_offsel  = 2'(osel);
    in_addrsel = 1'(asel);
    in_immsel  = 1'(isel);
    in_tag     = 4'(tag);
  endtask

  int op, ir, pc, sr1, sr2, bsel, osel, asel, isel, tag, n, seen;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_alu", 32'(out_alu), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    step();

    // ADD with immediate, then back-to-back ADDs
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(0, 16'h001F, 0, 16'h0005, 0, 0, 0, 1, 1, 3);
    step();
    chk("add_imm_valid", 32'(out_valid), 1);
    chk("add_imm_alu", 32'(out_alu), 32'h0004);
    chk("add_imm_tag", 32'(out_tag), 3);
    drive(0, 0, 0, 16'h1234, 16'h1111, 0, 0, 1, 0, 4);
    step();
    chk("add_b2b_alu", 32'(out_alu), 32'h2345);
    chk("add_b2b_tag", 32'(out_tag), 4);

    // Address generation
    drive(3, 16'h01FF, 16'h3000, 0, 0, 0, 2, 1, 0, 5);
    step();
    chk("addr_pc_adj9", 32'(out_address), 32'h2FFE);
    drive(3, 16'h0025, 16'h3000, 0, 0, 0, 2, 0, 0, 6);
    step();
    chk("addr_trap", 32'(out_address), 32'h004A);
    drive(3, 16'h0001, 16'h3000, 16'hFFFE, 0, 1, 1, 1, 0, 7);
    step();
    chk("addr_sr1_wrap", 32'(out_address), 32'h0000);

    // Shifts of 0x8000 by 4
    drive(7, 0, 0, 16'h8000, 4, 0, 0, 1, 0, 1);
    step();
    chk("sra", 32'(out_alu), 32'hF800);
    drive(6, 0, 0, 16'h8000, 4, 0, 0, 1, 0, 1);
    step();
    chk("srl", 32'(out_alu), 32'h0800);
    drive(5, 0, 0, 16'h8000, 4, 0, 0, 1, 0, 1);
    step();
    chk("sll", 32'(out_alu), 32'h0000);

    // MUL 3 x 7: exact latency, busy and in_ready during the multiply
    drive(8, 0, 16'h3000, 3, 7, 0, 0, 0, 0, 9);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("mul_busy", 32'(busy), 1);
      chk("mul_in_ready", 32'(in_ready), 0);
      chk("mul_not_valid", 32'(out_valid), 0);
      step();
    end
    chk("mul_done_valid", 32'(out_valid), 1);
    chk("mul_done_busy", 32'(busy), 0);
    chk("mul_3x7", 32'(out_alu), 32'h0015);
    chk("mul_tag", 32'(out_tag), 9);

    // MUL 0xFFFF x 0xFFFF
    in_valid = 1'b1;
    drive(8, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 1, 0, 10);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("mul_ffff_lat", 32'(n), 16);
    chk("mul_ffff", 32'(out_alu), 32'h0001);

    // MUL_ENABLE=0 variant returns 0 after one cycle
    drive(8, 0, 0, 3, 7, 0, 0, 1, 0, 2);
    nm_valid = 1'b1;
    step();
    nm_valid = 1'b0;
    chk("nomul_valid", 32'(nm_out_valid), 1);
    chk("nomul_alu", 32'(nm_out_alu), 0);
    chk("nomul_busy", 32'(nm_busy), 0);
    step();

    // Backpressure: stall holds the slot, release drains and refills on one edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(1, 0, 0, 16'hF0F0, 16'h3C3C, 0, 0, 1, 0, 11);
    step();
    drive(2, 0, 0, 16'h00FF, 0, 0, 0, 1, 0, 12);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_alu_a", 32'(out_alu), 32'h3030);
    step();
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_alu", 32'(out_alu), 32'h3030);
    chk("bp_hold_tag", 32'(out_tag), 11);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    step();
    chk("bp_refill_valid", 32'(out_valid), 1);
    chk("bp_refill_alu", 32'(out_alu), 32'hFF00);
    chk("bp_refill_tag", 32'(out_tag), 12);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(out_valid), 0);

    // Flush during MUL cycle 5
    in_valid = 1'b1;
    drive(8, 0, 0, 5, 5, 0, 0, 1, 0, 13);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (20) begin step(); if (out_valid) seen++; end
    chk("flush_no_emit", 32'(seen), 0);

    // Async reset mid-MUL with a nonzero stale slot
    in_valid = 1'b1;
    drive(4, 0, 0, 0, 16'hBEEF, 0, 0, 0, 0, 14);
    in_ir = 16'h0011;
    step();
    drive(8, 16'h0011, 0, 3, 7, 0, 0, 0, 0, 15);
    step();
    in_valid = 1'b0;
    chk("pre_rst_alu", 32'(out_alu), 32'hBEEF);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_alu", 32'(out_alu), 0);
    chk("arst_addr", 32'(out_address), 0);
    chk("arst_tag", 32'(out_tag), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin step(); if (out_valid) seen++; end
    chk("arst_no_emit", 32'(seen), 0);

    // Randomized back-to-back single-cycle ops
    out_ready = 1'b1;
    for (int k = 0; k < 120; k++) begin
      op = int'($urandom_range(0, 14));
      if (op >= 8) op++;
      ir = int'($urandom_range(0, 65535));
      pc = int'($urandom_range(0, 65535));
      sr1 = int'($urandom_range(0, 65535));
      sr2 = int'($urandom_range(0, 65535));
      bsel = int'($urandom_range(0, 1));
      osel = int'($urandom_range(0, 3));
      asel = int'($urandom_range(0, 1));
      isel = int'($urandom_range(0, 1));
      tag = int'($urandom_range(0, 15));
      drive(op, ir, pc, sr1, sr2, bsel, osel, asel, isel, tag);
      in_valid = 1'b1;
      step();
      chk("rnd_valid", 32'(out_valid), 1);
      chk("rnd_alu", 32'(out_alu), 32'(m_alu(op, sr1, m_b(ir, isel, sr2))));
      chk("rnd_addr", 32'(out_address), 32'(m_addr(ir, pc, sr1, bsel, osel, asel)));
      chk("rnd_tag", 32'(out_tag), 32'(tag));
    end

    // Randomized multiplies
    for (int k = 0; k < 6; k++) begin
      ir = int'($urandom_range(0, 65535));
      sr1 = int'($urandom_range(0, 65535));
      sr2 = int'($urandom_range(0, 65535));
      isel = int'($urandom_range(0, 1));
      tag = int'($urandom_range(0, 15));
      drive(8, ir, 16'h4000, sr1, sr2, 0, 2, 1, isel, tag);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin step(); n++; end
      chk("rmul_lat", 32'(n), 16);
      chk("rmul_alu", 32'(out_alu), 32'(m_alu(8, sr1, m_b(ir, isel, sr2))));
      chk("rmul_addr", 32'(out_address), 32'(m_addr(ir, 16'h4000, sr1, 0, 2, 1)));
      chk("rmul_tag", 32'(out_tag), 32'(tag));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
